// File: rtl/cache_line_xfer.sv
// cache_line_xfer: moves one cache line between a cache and a beat-wide bus.
// A fill request reads LINELEN/BEATW beats into FetchBuffer. A writeback
// request writes the same number of beats taken from CacheWriteWord.
// Each burst ends with a one-cycle CacheBusAck pulse.
module cache_line_xfer #(
    parameter int PA_BITS = 34,
    parameter int LINELEN = 256,
    parameter int BEATW   = 64,
    parameter int LOGBWPL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATW-1:0]   CacheWriteWord,
    output logic               CacheBusAck,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               BusCommitted,
    output logic               BusReq,
    output logic               BusWrite,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATW-1:0]   BusWData,
    input  logic               BusReady,
    input  logic [BEATW-1:0]   BusRData
);

    localparam int BEATS   = LINELEN / BEATW;
    localparam int OFFSET  = $clog2(LINELEN / 8);
    localparam int BEATOFF = $clog2(BEATW / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [LOGBWPL-1:0]   r_beatCount;
    logic [LINELEN-1:0]   r_fetchBuffer;
    logic                 w_inBurst;
    logic                 w_beatAccepted;
    logic                 w_lastBeat;
    logic                 w_unusedAdrBits;

    assign w_inBurst       = (r_state == WRITE) || (r_state == READ);
    assign w_beatAccepted  = w_inBurst && BusReady;
    assign w_lastBeat      = (r_beatCount == LOGBWPL'(BEATS - 1));
    assign w_unusedAdrBits = ^CacheBusAdr[OFFSET-1:0];

    // State register. Reset wins over everything, so a partial burst is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Writeback wins over fill. DONE always returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (CacheBusRW[0]) begin
                    w_nextState = WRITE;
                end else if (CacheBusRW[1]) begin
                    w_nextState = READ;
                end
            end
            WRITE, READ: begin
                if (w_beatAccepted && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Beat counter. It is held at zero in IDLE so every burst starts at beat 0.
    // It advances only on accepted beats and wraps to 0 after the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beatCount <= '0;
        end else if (r_state == IDLE) begin
            r_beatCount <= '0;
        end else if (w_beatAccepted) begin
            r_beatCount <= r_beatCount + LOGBWPL'(1);
        end
    end

    // Fill line assembly. Only the slice for the accepted beat is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetchBuffer <= '0;
        end else if ((r_state == READ) && BusReady) begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_beatCount == LOGBWPL'(b)) begin
                    r_fetchBuffer[b*BEATW +: BEATW] <= BusRData;
                end
            end
        end
    end

    assign CacheBusAck  = (r_state == DONE);
    assign SelBusBeat   = (r_state == WRITE);
    assign BusCommitted = (r_state != IDLE);
    assign BusReq       = w_inBurst;
    assign BusWrite     = (r_state == WRITE);
    assign BusAdr       = {CacheBusAdr[PA_BITS-1:OFFSET], r_beatCount, {BEATOFF{1'b0}}};
    assign BusWData     = CacheWriteWord;
    assign BeatCount    = r_beatCount;
    assign FetchBuffer  = r_fetchBuffer;

endmodule

// File: tb/tb_cache_line_xfer.sv
// tb_cache_line_xfer: directed checks of cache_line_xfer. Every expected
// value below is a hand-computed constant.
module tb_cache_line_xfer;

    localparam int PA_BITS = 34;
    localparam int LINELEN = 256;
    localparam int BEATW   = 64;
    localparam int LOGBWPL = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [BEATW-1:0]   CacheWriteWord;
    logic               CacheBusAck;
    logic               SelBusBeat;
    logic [LOGBWPL-1:0] BeatCount;
    logic [LINELEN-1:0] FetchBuffer;
    logic               BusCommitted;
    logic               BusReq;
    logic               BusWrite;
    logic [PA_BITS-1:0] BusAdr;
    logic [BEATW-1:0]   BusWData;
    logic               BusReady;
    logic [BEATW-1:0]   BusRData;

    int compareCount = 0;
    int failCount    = 0;

    cache_line_xfer #(
        .PA_BITS(PA_BITS),
        .LINELEN(LINELEN),
        .BEATW  (BEATW),
        .LOGBWPL(LOGBWPL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .CacheBusRW    (CacheBusRW),
        .CacheBusAdr   (CacheBusAdr),
        .CacheWriteWord(CacheWriteWord),
        .CacheBusAck   (CacheBusAck),
        .SelBusBeat    (SelBusBeat),
        .BeatCount     (BeatCount),
        .FetchBuffer   (FetchBuffer),
        .BusCommitted  (BusCommitted),
        .BusReq        (BusReq),
        .BusWrite      (BusWrite),
        .BusAdr        (BusAdr),
        .BusWData      (BusWData),
        .BusReady      (BusReady),
        .BusRData      (BusRData)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Move to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive all cache-side and bus-side inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] rw, input logic [PA_BITS-1:0] adr,
                                 input logic ready, input logic [BEATW-1:0] rdata,
                                 input logic [BEATW-1:0] wword);
        CacheBusRW     = rw;
        CacheBusAdr    = adr;
        BusReady       = ready;
        BusRData       = rdata;
        CacheWriteWord = wword;
        #1;
    endtask

    // One comparison. A mismatch is counted and reported.
    task automatic checkOutput(input string tag, input logic [LINELEN-1:0] observed,
                               input logic [LINELEN-1:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outputs expected while the block is IDLE.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_req"},    256'(BusReq),       256'(0));
        checkOutput({tag, "_ack"},    256'(CacheBusAck),  256'(0));
        checkOutput({tag, "_commit"}, 256'(BusCommitted), 256'(0));
    endtask

    // Outputs expected during one beat of a WRITE or READ burst.
    task automatic checkBeat(input string tag, input logic isWrite, input int beat,
                             input logic [PA_BITS-1:0] base);
        logic [PA_BITS-1:0] expAdr;
        expAdr = base + PA_BITS'(beat * 8);
        checkOutput({tag, "_req"},   256'(BusReq),      256'(1));
        checkOutput({tag, "_write"}, 256'(BusWrite),    256'(isWrite));
        checkOutput({tag, "_sel"},   256'(SelBusBeat),  256'(isWrite));
        checkOutput({tag, "_beat"},  256'(BeatCount),   256'(beat));
        checkOutput({tag, "_adr"},   256'(BusAdr),      256'(expAdr));
        checkOutput({tag, "_ack"},   256'(CacheBusAck), 256'(0));
    endtask

    logic [PA_BITS-1:0] adrA = 34'h0_8000_1040;
    logic [PA_BITS-1:0] adrW = 34'h3_ABCD_EF00;
    logic [PA_BITS-1:0] adrC = 34'h1_2345_6780;

    logic [BEATW-1:0] fillData  [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                        64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [BEATW-1:0] wbData    [4] = '{64'hC0DE_0000_0000_00A0, 64'hC0DE_0000_0000_00A1,
                                        64'hC0DE_0000_0000_00A2, 64'hC0DE_0000_0000_00A3};
    logic [BEATW-1:0] comboData [4] = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                                        64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    logic [BEATW-1:0] stallData [4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                        64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    logic [BEATW-1:0] dropData  [4] = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                                        64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738};
    logic [BEATW-1:0] junkData      = 64'hEEEE_EEEE_EEEE_EEEE;

    logic [LINELEN-1:0] fillExp  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    logic [LINELEN-1:0] comboExp = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                    64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    logic [LINELEN-1:0] stallExp = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    logic [LINELEN-1:0] dropExp  = {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                                    64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708};

    // Stall pattern: beat 2 waits three cycles with BusReady low.
    logic stallReady [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   stallBeat  [7] = '{0, 1, 2, 2, 2, 2, 3};

    // Directed sequence: reset, fill, writeback, combined, stall, reset mid-burst, dropped request.
    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, '0, 1'b0, '0, '0);
        nextCycle();
        nextCycle();
        checkIdle("reset");
        checkOutput("reset_write", 256'(BusWrite),   256'(0));
        checkOutput("reset_sel",   256'(SelBusBeat), 256'(0));
        checkOutput("reset_beat",  256'(BeatCount),  256'(0));
        checkOutput("reset_fb",    FetchBuffer,      256'(0));
        reset = 1'b0;

        $display("[TB] fill burst");
        applyStimulus(2'b10, adrA, 1'b1, '0, '0);
        checkIdle("fill_c0");
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(2'b10, adrA, 1'b1, fillData[b], '0);
            checkBeat($sformatf("fill_b%0d", b), 1'b0, b, adrA);
        end
        nextCycle();
        applyStimulus(2'b00, adrA, 1'b1, '0, '0);
        checkOutput("fill_ack",    256'(CacheBusAck),  256'(1));
        checkOutput("fill_donereq", 256'(BusReq),      256'(0));
        checkOutput("fill_commit", 256'(BusCommitted), 256'(1));
        checkOutput("fill_fb",     FetchBuffer,        fillExp);
        nextCycle();
        checkIdle("fill_after");
        checkOutput("fill_fbhold", FetchBuffer, fillExp);

        $display("[TB] writeback burst");
        applyStimulus(2'b01, adrW, 1'b1, '0, wbData[0]);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(2'b01, adrW, 1'b1, junkData, wbData[b]);
            checkBeat($sformatf("wb_b%0d", b), 1'b1, b, adrW);
            checkOutput($sformatf("wb_wdata%0d", b), 256'(BusWData), 256'(wbData[b]));
        end
        nextCycle();
        applyStimulus(2'b00, adrW, 1'b1, '0, '0);
        checkOutput("wb_ack", 256'(CacheBusAck), 256'(1));
        checkOutput("wb_sel", 256'(SelBusBeat),  256'(0));
        checkOutput("wb_fb",  FetchBuffer,       fillExp);
        nextCycle();
        checkIdle("wb_after");

        $display("[TB] combined writeback then fill");
        applyStimulus(2'b11, adrC, 1'b1, '0, wbData[0]);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(2'b11, adrC, 1'b1, junkData, wbData[b]);
            checkBeat($sformatf("cmb_w%0d", b), 1'b1, b, adrC);
        end
        nextCycle();
        applyStimulus(2'b10, adrC, 1'b1, '0, '0);
        checkOutput("cmb_ack1", 256'(CacheBusAck), 256'(1));
        checkOutput("cmb_req1", 256'(BusReq),      256'(0));
        nextCycle();
        applyStimulus(2'b10, adrC, 1'b1, '0, '0);
        checkIdle("cmb_idle");
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(2'b10, adrC, 1'b1, comboData[b], '0);
            checkBeat($sformatf("cmb_r%0d", b), 1'b0, b, adrC);
        end
        nextCycle();
        applyStimulus(2'b00, adrC, 1'b1, '0, '0);
        checkOutput("cmb_ack2", 256'(CacheBusAck), 256'(1));
        checkOutput("cmb_fb",   FetchBuffer,       comboExp);
        nextCycle();
        checkIdle("cmb_after");

        $display("[TB] fill with stall at beat 2");
        applyStimulus(2'b10, adrA, 1'b1, '0, '0);
        for (int c = 0; c < 7; c++) begin
            nextCycle();
            applyStimulus(2'b10, adrA, stallReady[c],
                          stallReady[c] ? stallData[stallBeat[c]] : junkData, '0);
            checkBeat($sformatf("stall_c%0d", c + 1), 1'b0, stallBeat[c], adrA);
        end
        nextCycle();
        applyStimulus(2'b00, adrA, 1'b1, '0, '0);
        checkOutput("stall_ack8", 256'(CacheBusAck), 256'(1));
        checkOutput("stall_fb",   FetchBuffer,       stallExp);
        nextCycle();
        checkIdle("stall_after");

        $display("[TB] reset during fill");
        applyStimulus(2'b10, adrA, 1'b1, '0, '0);
        nextCycle();
        applyStimulus(2'b10, adrA, 1'b1, 64'h1234_1234_1234_1234, '0);
        checkBeat("rst_b0", 1'b0, 0, adrA);
        nextCycle();
        reset = 1'b1;
        applyStimulus(2'b10, adrA, 1'b1, 64'h5678_5678_5678_5678, '0);
        checkBeat("rst_b1", 1'b0, 1, adrA);
        nextCycle();
        reset = 1'b0;
        applyStimulus(2'b00, adrA, 1'b1, '0, '0);
        checkIdle("rst_mid");
        checkOutput("rst_beat", 256'(BeatCount), 256'(0));
        checkOutput("rst_fb",   FetchBuffer,     256'(0));
        nextCycle();
        checkIdle("rst_after");
        checkOutput("rst_fbhold", FetchBuffer, 256'(0));

        $display("[TB] request dropped mid-burst");
        applyStimulus(2'b10, adrA, 1'b1, '0, '0);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus((b >= 2) ? 2'b00 : 2'b10, adrA, 1'b1, dropData[b], '0);
            checkBeat($sformatf("drop_b%0d", b), 1'b0, b, adrA);
        end
        nextCycle();
        checkOutput("drop_ack", 256'(CacheBusAck), 256'(1));
        checkOutput("drop_fb",  FetchBuffer,       dropExp);
        nextCycle();
        checkIdle("drop_after");
        nextCycle();
        checkIdle("drop_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
